// File: rtl/brick_field_mapper_if.sv
// Pixel, game-object and brick-hit signals shared by the Breakout colour mapper.
interface brick_field_mapper_if;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank_n;
    logic [9:0] BallX;
    logic [9:0] BallY;
    logic [9:0] Ball_size;
    logic [9:0] PaddleX;
    logic [9:0] PaddleW;
    logic       hit_valid;
    logic [3:0] hit_row;
    logic [4:0] hit_col;
    logic       reload;
    logic       hit_ack;
    logic       hit_was_alive;
    logic [8:0] bricks_left;
    logic       all_cleared;
    logic [7:0] Red;
    logic [7:0] Green;
    logic [7:0] Blue;

    modport master (
        output DrawX, DrawY, blank_n, BallX, BallY, Ball_size, PaddleX, PaddleW,
               hit_valid, hit_row, hit_col, reload,
        input  hit_ack, hit_was_alive, bricks_left, all_cleared, Red, Green, Blue
    );

    modport slave (
        input  DrawX, DrawY, blank_n, BallX, BallY, Ball_size, PaddleX, PaddleW,
               hit_valid, hit_row, hit_col, reload,
        output hit_ack, hit_was_alive, bricks_left, all_cleared, Red, Green, Blue
    );
endinterface

// File: rtl/brick_field_mapper.sv
// Two-stage pixel colour pipeline for Breakout: ball, paddle, brick field and
// gradient background, plus the brick-alive bitmap and hit bookkeeping.
module brick_field_mapper #(
    parameter int unsigned BRICK_COLS   = 10,
    parameter int unsigned BRICK_ROWS   = 6,
    parameter int unsigned BRICK_W_LOG2 = 6,
    parameter int unsigned BRICK_H_LOG2 = 4,
    parameter int unsigned FIELD_Y0     = 48,
    parameter int unsigned PADDLE_Y     = 456
) (
    input  logic               Clk,
    input  logic               Reset_n,
    brick_field_mapper_if.slave bus
);
    localparam int unsigned N_BRICKS = BRICK_ROWS * BRICK_COLS;
    localparam int unsigned IDX_W    = (N_BRICKS > 1) ? $clog2(N_BRICKS) : 1;
    localparam int unsigned COL_W    = 10 - BRICK_W_LOG2;
    localparam int unsigned FIELD_Y1 = FIELD_Y0 + BRICK_ROWS * (2 ** BRICK_H_LOG2);
    localparam logic [8:0]  FULL_CNT = 9'(N_BRICKS);

    // ---------------- stage 1: geometry ----------------
    logic signed [10:0] dist_x, dist_y;
    logic [10:0]        abs_x, abs_y;
    logic [21:0]        dist_sq, rad_sq;
    logic [9:0]         field_y;
    logic [BRICK_W_LOG2-1:0] loc_x;
    logic [BRICK_H_LOG2-1:0] loc_y;

    logic             blank_n_d, blank_n_q;
    logic             ball_on_d, ball_on_q;
    logic             paddle_on_d, paddle_on_q;
    logic             in_field_d, in_field_q;
    logic             border_d, border_q;
    logic [3:0]       row_d, row_q;
    logic [COL_W-1:0] col_d, col_q;
    logic [6:0]       xhi_d, xhi_q;

    always_comb begin
        dist_x  = signed'({1'b0, bus.DrawX}) - signed'({1'b0, bus.BallX});
        dist_y  = signed'({1'b0, bus.DrawY}) - signed'({1'b0, bus.BallY});
        abs_x   = dist_x[10] ? 11'(-dist_x) : 11'(dist_x);
        abs_y   = dist_y[10] ? 11'(-dist_y) : 11'(dist_y);
        dist_sq = 22'(abs_x) * 22'(abs_x) + 22'(abs_y) * 22'(abs_y);
        rad_sq  = 22'(bus.Ball_size) * 22'(bus.Ball_size);
        field_y = bus.DrawY - 10'(FIELD_Y0);
        loc_x   = bus.DrawX[BRICK_W_LOG2-1:0];
        loc_y   = field_y[BRICK_H_LOG2-1:0];

        blank_n_d   = bus.blank_n;
        ball_on_d   = (dist_sq <= rad_sq);
        paddle_on_d = (bus.DrawX >= bus.PaddleX) &&
                      (11'(bus.DrawX) < 11'(bus.PaddleX) + 11'(bus.PaddleW)) &&
                      (11'(bus.DrawY) >= 11'(PADDLE_Y)) &&
                      (11'(bus.DrawY) <  11'(PADDLE_Y + 8));
        row_d       = 4'(field_y >> BRICK_H_LOG2);
        col_d       = bus.DrawX[9:BRICK_W_LOG2];
        in_field_d  = (11'(bus.DrawY) >= 11'(FIELD_Y0)) &&
                      (11'(bus.DrawY) <  11'(FIELD_Y1)) &&
                      (32'(col_d) < BRICK_COLS);
        border_d    = (loc_x == '0) || (loc_x == '1) || (loc_y == '0) || (loc_y == '1);
        xhi_d       = bus.DrawX[9:3];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            blank_n_q   <= 1'b0;
            ball_on_q   <= 1'b0;
            paddle_on_q <= 1'b0;
            in_field_q  <= 1'b0;
            border_q    <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            xhi_q       <= '0;
        end else begin
            blank_n_q   <= blank_n_d;
            ball_on_q   <= ball_on_d;
            paddle_on_q <= paddle_on_d;
            in_field_q  <= in_field_d;
            border_q    <= border_d;
            row_q       <= row_d;
            col_q       <= col_d;
            xhi_q       <= xhi_d;
        end
    end

    // ---------------- brick bitmap and hit handling ----------------
    logic [N_BRICKS-1:0] alive_d, alive_q;
    logic [8:0]          count_d, count_q;
    logic                hit_ack_d, hit_ack_q;
    logic                was_alive_d, was_alive_q;
    logic                cleared_d, cleared_q;
    logic [IDX_W-1:0]    hit_idx;
    logic                hit_in_range;

    always_comb begin
        hit_idx      = IDX_W'(32'(bus.hit_row) * BRICK_COLS + 32'(bus.hit_col));
        hit_in_range = (32'(bus.hit_row) < BRICK_ROWS) && (32'(bus.hit_col) < BRICK_COLS);
        alive_d      = alive_q;
        count_d      = count_q;
        hit_ack_d    = bus.hit_valid;
        was_alive_d  = 1'b0;
        if (bus.reload) begin
            alive_d = '1;
            count_d = FULL_CNT;
        end else if (bus.hit_valid && hit_in_range && alive_q[hit_idx]) begin
            alive_d[hit_idx] = 1'b0;
            was_alive_d      = 1'b1;
            if (count_q != 9'd0) count_d = count_q - 9'd1;
        end
        cleared_d = (count_d == 9'd0);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            alive_q     <= '1;
            count_q     <= FULL_CNT;
            hit_ack_q   <= 1'b0;
            was_alive_q <= 1'b0;
            cleared_q   <= 1'b0;
        end else begin
            alive_q     <= alive_d;
            count_q     <= count_d;
            hit_ack_q   <= hit_ack_d;
            was_alive_q <= was_alive_d;
            cleared_q   <= cleared_d;
        end
    end

    // ---------------- stage 2: lookup and priority mux ----------------
    logic [IDX_W-1:0] pix_idx;
    logic             brick_live;
    logic [23:0]      rgb_d, rgb_q;

    always_comb begin
        pix_idx    = IDX_W'(32'(row_q) * BRICK_COLS + 32'(col_q));
        brick_live = in_field_q && alive_q[pix_idx];
        rgb_d      = {16'h0000, 8'h7F - {1'b0, xhi_q}};
        if (!blank_n_q) begin
            rgb_d = 24'h000000;
        end else if (ball_on_q) begin
            rgb_d = 24'hFF5500;
        end else if (paddle_on_q) begin
            rgb_d = 24'hFFFFFF;
        end else if (brick_live && border_q) begin
            rgb_d = 24'hD2D1CD;
        end else if (brick_live) begin
            case (row_q[1:0])
                2'd0:    rgb_d = 24'h77603F;
                2'd1:    rgb_d = 24'hB03030;
                2'd2:    rgb_d = 24'h309030;
                default: rgb_d = 24'h3050B0;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) rgb_q <= '0;
        else          rgb_q <= rgb_d;
    end

    assign bus.Red           = rgb_q[23:16];
    assign bus.Green         = rgb_q[15:8];
    assign bus.Blue          = rgb_q[7:0];
    assign bus.hit_ack       = hit_ack_q;
    assign bus.hit_was_alive = was_alive_q;
    assign bus.bricks_left   = count_q;
    assign bus.all_cleared   = cleared_q;
endmodule
